// File: rtl/timer_pkg.sv
// Shared constants for the MM:SS scan timer.
//   - control codes carried on the scan_timer state input
//   - active-low seven-segment patterns {g,f,e,d,c,b,a} for digits 0-9
//   - blank pattern and the reset values of the display outputs
//   - onecold(): scan index to active-low anode vector
package timer_pkg;

  localparam logic [1:0] ST_RESET = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd1;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_RESET  = 4'b1110;
  localparam logic [7:0] SEG_RESET = 8'hC0;

  // Exactly one bit low: the anode of the selected digit.
  function automatic logic [3:0] onecold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_timer_seg7_decode.sv
// seg7_decode: purely combinational BCD to seven-segment decoder.
//   bcd : 4-bit digit value
//   seg : active-low segments {g,f,e,d,c,b,a}; values 10-15 show blank
module seg7_decode
  import timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scan_timer.sv
// scan_timer: MM:SS stopwatch with a multiplexed four-digit display.
//   clk         : system clock, the only clock
//   rst         : asynchronous active-high reset
//   state       : RESET_STATE clears, RUN_STATE counts, any other code pauses
//   oneHz_CLK   : one-clk pulse per second (enable)
//   display_CLK : one-clk digit refresh pulse (enable)
//   seg         : active-low cathodes {dp,g,f,e,d,c,b,a}, registered
//   an          : active-low anodes, an[3] leftmost, registered
//   bcd_time    : {min_tens,min_ones,sec_tens,sec_ones}
//
// Handshake: there is none; oneHz_CLK and display_CLK are single-cycle
// enables sampled on every rising clk edge, with no back-pressure.
module scan_timer
  import timer_pkg::*;
#(
  parameter logic [1:0] RESET_STATE = ST_RESET,
  parameter logic [1:0] RUN_STATE   = ST_RUN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        oneHz_CLK,
  input  logic        display_CLK,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] bcd_time
);

  logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
  logic [3:0] sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
  logic [1:0] scan_idx_q, scan_idx_d;
  logic       blink_q, blink_d;
  logic       running, clearing, paused, advance;
  logic [3:0] digit_sel;
  logic [6:0] digit_seg;
  logic       dp_n;

  assign running  = (state == RUN_STATE);
  assign clearing = (state == RESET_STATE);
  assign paused   = !running && !clearing;
  assign advance  = running && oneHz_CLK;

  // BCD count with a digit-by-digit carry chain; 59:59 wraps silently.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    if (clearing) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (advance) begin
      if (sec_ones_q == 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q == 4'd5) begin
          sec_tens_d = 4'd0;
          if (min_ones_q == 4'd9) begin
            min_ones_d = 4'd0;
            min_tens_d = (min_tens_q == 4'd5) ? 4'd0 : min_tens_q + 4'd1;
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end
  end

  assign scan_idx_d = display_CLK ? scan_idx_q + 2'd1 : scan_idx_q;
  // Colon blink phase only moves while paused.
  assign blink_d    = blink_q ^ (paused & oneHz_CLK);

  // Display samples the pre-update count so a coincident second tick
  // shows up on the following refresh, never half-applied.
  always_comb begin
    digit_sel = sec_ones_q;
    case (scan_idx_d)
      2'd0: digit_sel = sec_ones_q;
      2'd1: digit_sel = sec_tens_q;
      2'd2: digit_sel = min_ones_q;
      2'd3: digit_sel = min_tens_q;
      default: digit_sel = sec_ones_q;
    endcase
  end

  seg7_decode u_decode (
    .bcd (digit_sel),
    .seg (digit_seg)
  );

  // Colon lives on digit 2: steady while running, blinking while paused.
  assign dp_n = !((scan_idx_d == 2'd2) && (running || !blink_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      scan_idx_q <= 2'd0;
      blink_q    <= 1'b0;
      an         <= AN_RESET;
      seg        <= SEG_RESET;
    end else begin
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      scan_idx_q <= scan_idx_d;
      blink_q    <= blink_d;
      an         <= onecold(scan_idx_d);
      seg        <= {dp_n, digit_seg};
    end
  end

  assign bcd_time = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};

endmodule
